symbol_mapper: RTL and testbench

- Downstream stage of the convolutional encoder.
- Starts when the encoder raises start_mapper. Reads the 16-bit encoded words from the encoded-bits dual-port RAM over port B (address_D / ram_output).
- Slices each word into symbols according to modulation_type and converts each symbol to a signed I/Q pair.
- Delivers I/Q pairs over a valid/ready stream to the modulator back end, then asserts done_mapper.

---
 rtl/symbol_mapper.sv | 164 ++++++++++++++++
 tb/tb_symbol_mapper.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/symbol_mapper.sv
// symbol_mapper: reads encoded words from RAM port B, slices them into symbols and streams
// Gray-mapped signed I/Q pairs. Define MAPPER_SYMCNT_EN to add the sym_count handshake counter.
module symbol_mapper #(
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = 5,
    parameter int UNIT      = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_mapper,
    input  logic [3:0]        modulation_type,
    output logic [ADDR_W-1:0] address_D,
    input  logic [15:0]       ram_output,
    output logic [31:0]       IQ,
    output logic              iq_valid,
    input  logic              iq_ready,
    output logic              done_mapper,
    output logic              mod_err
`ifdef MAPPER_SYMCNT_EN
    ,
    output logic [15:0]       sym_count
`endif
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] EMIT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int                WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);

    logic [2:0]        state;
    logic              start_prev;
    logic [1:0]        mode;
    logic [15:0]       word;
    logic [3:0]        sym_idx;
    logic [WIDX_W-1:0] word_idx;

    logic        start_edge;
    logic        handshake;
    logic        last_sym;
    logic [3:0]  last_idx;
    logic [3:0]  shift;
    logic [7:0]  sym;
    logic [15:0] i_comp;
    logic [15:0] q_comp;

    // Field is Gray coded MSB first; a zero-extended field decodes to the same binary value.
    function automatic logic [15:0] component(input logic [3:0] field, input int w);
        logic [3:0] n;
        int         level;
        n[3]  = field[3];
        n[2]  = n[3] ^ field[2];
        n[1]  = n[2] ^ field[1];
        n[0]  = n[1] ^ field[0];
        level = 2 * int'(n) - ((1 << w) - 1);
        return 16'(level * UNIT);
    endfunction

    assign start_edge  = start_mapper & ~start_prev;
    assign iq_valid    = (state == EMIT);
    assign done_mapper = (state == DONE);
    assign handshake   = iq_valid & iq_ready;
    assign last_sym    = (sym_idx == last_idx);
    assign IQ          = iq_valid ? {i_comp, q_comp} : 32'd0;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        i_comp   = 16'd0;
        q_comp   = 16'd0;
        last_idx = 4'd15;
        shift    = sym_idx << mode;
        sym      = 8'(word >> shift);
        case (mode)
            2'd0: begin
                i_comp   = component({3'b000, sym[0]}, 1);
                last_idx = 4'd15;
            end
            2'd1: begin
                i_comp   = component({3'b000, sym[0]}, 1);
                q_comp   = component({3'b000, sym[1]}, 1);
                last_idx = 4'd7;
            end
            2'd2: begin
                i_comp   = component({2'b00, sym[1:0]}, 2);
                q_comp   = component({2'b00, sym[3:2]}, 2);
                last_idx = 4'd3;
            end
            default: begin
                i_comp   = component(sym[3:0], 4);
                q_comp   = component(sym[7:4], 4);
                last_idx = 4'd1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            start_prev <= 1'b0;
            mode       <= 2'd0;
            word       <= 16'd0;
            sym_idx    <= 4'd0;
            word_idx   <= '0;
            address_D  <= '0;
            mod_err    <= 1'b0;
        end else begin
            start_prev <= start_mapper;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        mod_err <= 1'b0;
                        if (modulation_type > 4'd3) begin
                            // Unsupported mode: address_D is deliberately left untouched.
                            mod_err <= 1'b1;
                            state   <= DONE;
                        end else begin
                            mode      <= modulation_type[1:0];
                            address_D <= '0;
                            word_idx  <= '0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: state <= LOAD;
                LOAD: begin
                    word      <= ram_output;
                    sym_idx   <= 4'd0;
                    address_D <= address_D + ADDR_W'(1);
                    state     <= EMIT;
                end
                EMIT: begin
                    if (handshake) begin
                        if (!last_sym) begin
                            sym_idx <= sym_idx + 4'd1;
                        end else if (word_idx == LAST_WORD) begin
                            state <= DONE;
                        end else begin
                            word_idx <= word_idx + WIDX_W'(1);
                            state    <= REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAPPER_SYMCNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            sym_count <= 16'd0;
        end else if ((state == IDLE || state == DONE) && start_edge) begin
            sym_count <= 16'd0;
        end else if (handshake && sym_count != 16'hFFFF) begin
            sym_count <= sym_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_symbol_mapper.sv
// tb_symbol_mapper: random-backpressure frames on every modulation, compared against a
// behavioural Gray/level model; also covers unsupported mode, start-level hold and mid-frame reset.
module tb_symbol_mapper;

    localparam int NUM_WORDS = 16;
    localparam int ADDR_W    = 5;
    localparam int UNIT      = 1024;
    localparam int BUDGET    = 5000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_mapper = 1'b0;
    logic [3:0]        modulation_type = 4'd0;
    logic              iq_ready = 1'b0;
    logic [ADDR_W-1:0] address_D;
    logic [15:0]       ram_output;
    logic [31:0]       IQ;
    logic              iq_valid;
    logic              done_mapper;
    logic              mod_err;
`ifdef MAPPER_SYMCNT_EN
    logic [15:0]       sym_count;
`endif

    logic [15:0]       mem [32];
    logic [ADDR_W-1:0] addr_before;
    int                n_checks = 0;
    int                n_pass   = 0;
    int                wait_cnt;

    symbol_mapper #(.NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .UNIT(UNIT)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_mapper    (start_mapper),
        .modulation_type (modulation_type),
        .address_D       (address_D),
        .ram_output      (ram_output),
        .IQ              (IQ),
        .iq_valid        (iq_valid),
        .iq_ready        (iq_ready),
        .done_mapper     (done_mapper),
        .mod_err         (mod_err)
`ifdef MAPPER_SYMCNT_EN
        ,
        .sym_count       (sym_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data follows the address by one cycle.
    always @(posedge clk) ram_output <= mem[address_D];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [15:0] level_comp(input int field, input int w);
        int n;
        n = 0;
        for (int sh = 0; sh < 4; sh++) n = n ^ (field >> sh);
        return 16'((2 * n - ((1 << w) - 1)) * UNIT);
    endfunction

    function automatic logic [31:0] ref_symbol(input logic [15:0] word, input int mode, input int k);
        int b;
        int s;
        b = 1 << mode;
        s = (int'(word) >> (k * b)) & ((1 << b) - 1);
        case (mode)
            0:       return {level_comp(s & 1, 1), 16'h0000};
            1:       return {level_comp(s & 1, 1), level_comp((s >> 1) & 1, 1)};
            2:       return {level_comp(s & 3, 2), level_comp((s >> 2) & 3, 2)};
            default: return {level_comp(s & 15, 4), level_comp((s >> 4) & 15, 4)};
        endcase
    endfunction

    task automatic load_mem(input logic [15:0] w0, input bit rnd);
        for (int i = 0; i < 32; i++) mem[i] = rnd ? 16'($urandom) : 16'h0000;
        if (!rnd) mem[0] = w0;
    endtask

    task automatic run_frame(input int mode, input int ready_pct);
        logic [31:0] exp_q[$];
        logic [31:0] held;
        bit          stalled;
        bit          seen;
        int          got;
        int          latency;
        int          gap;
        int          cycles;
        for (int w = 0; w < NUM_WORDS; w++)
            for (int k = 0; k < (16 >> mode); k++)
                exp_q.push_back(ref_symbol(mem[w], mode, k));
        @(negedge clk);
        start_mapper    = 1'b0;
        modulation_type = 4'(mode);
        iq_ready        = 1'b0;
        @(negedge clk);
        start_mapper = 1'b1;
        stalled = 1'b0; seen = 1'b0; held = 32'd0;
        got = 0; latency = 0; gap = 0; cycles = 0;
        while (cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
            if (done_mapper) break;
            if (stalled) begin
                check("stall_valid", 32'(iq_valid), 32'd1);
                check("stall_iq", IQ, held);
            end
            iq_ready = ($urandom_range(99) < ready_pct);
            if (iq_valid && !seen) begin
                seen    = 1'b1;
                latency = cycles;
            end
            if (seen && !iq_valid) gap++;
            if (iq_valid && iq_ready) begin
                if (got < exp_q.size()) check($sformatf("iq_m%0d[%0d]", mode, got), IQ, exp_q[got]);
                got++;
            end
            stalled = iq_valid && !iq_ready;
            held    = IQ;
        end
        check("frame_done", 32'(done_mapper), 32'd1);
        check("first_latency", 32'(latency), 32'd3);
        check("word_bubbles", 32'(gap), 32'(2 * (NUM_WORDS - 1)));
        check("symbol_total", 32'(got), 32'(exp_q.size()));
        check("done_mod_err", 32'(mod_err), 32'd0);
        check("done_addr", 32'(address_D), 32'(NUM_WORDS));
`ifdef MAPPER_SYMCNT_EN
        check("sym_count", 32'(sym_count), 32'(got));
`endif
        repeat (4) begin
            @(negedge clk);
            check("hold_no_restart", 32'({iq_valid, done_mapper}), 32'b01);
        end
        start_mapper = 1'b0;
        iq_ready     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(address_D), 32'd0);
        check("rst_iq", IQ, 32'd0);
        check("rst_valid", 32'(iq_valid), 32'd0);
        check("rst_done", 32'(done_mapper), 32'd0);
        check("rst_mod_err", 32'(mod_err), 32'd0);
`ifdef MAPPER_SYMCNT_EN
        check("rst_sym_count", 32'(sym_count), 32'd0);
`endif
        rst = 1'b1;

        load_mem(16'h0006, 1'b0); run_frame(1, 100);
        load_mem(16'h00B4, 1'b0); run_frame(2, 70);
        load_mem(16'h00F0, 1'b0); run_frame(3, 50);
        load_mem(16'h0001, 1'b0); run_frame(0, 100);
        for (int i = 0; i < 4; i++) begin
            load_mem(16'h0000, 1'b1);
            run_frame(int'($urandom_range(3)), 30 + int'($urandom_range(70)));
        end

        // Unsupported mode from DONE: no reads, immediate DONE with mod_err.
        @(negedge clk);
        addr_before     = address_D;
        modulation_type = 4'd7;
        start_mapper    = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bad_mode_state", 32'({iq_valid, done_mapper, mod_err}), 32'b011);
            check("bad_mode_addr", 32'(address_D), 32'(addr_before));
        end
        load_mem(16'h0000, 1'b1);
        run_frame(1, 80);

        // Reset in the middle of symbol emission, then a complete fresh frame.
        load_mem(16'h0000, 1'b1);
        @(negedge clk);
        start_mapper    = 1'b0;
        modulation_type = 4'd2;
        @(negedge clk);
        start_mapper = 1'b1;
        iq_ready     = 1'b1;
        wait_cnt     = 0;
        while (!(iq_valid && wait_cnt >= 8) && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reached_emit", 32'(iq_valid), 32'd1);
        rst          = 1'b0;
        start_mapper = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(iq_valid), 32'd0);
        check("mid_rst_addr", 32'(address_D), 32'd0);
        check("mid_rst_iq", IQ, 32'd0);
        check("mid_rst_done", 32'(done_mapper), 32'd0);
`ifdef MAPPER_SYMCNT_EN
        check("mid_rst_sym_count", 32'(sym_count), 32'd0);
`endif
        rst = 1'b1;
        run_frame(2, 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
